qmac_accum: RTL and testbench
=============================

Name: qmac_accum

Overview:
Streaming multiply-accumulate stage that consumes operand pairs in signed fixed-point Q(N-Q).Q format (default Q10.22). Each pair goes through a qmult instance, one pair per accepted beat. The products are summed over a framed vector that ends at the beat marked last, and the saturated N-bit dot product is emitted. It sits directly downstream of qmult and feeds the layer/activation logic over a valid/ready handshake.

Parameters:
N, 32, total operand/result width
Q, 22, fractional bits (passed to qmult)
G, 8, accumulator guard bits; accumulator width is N+G

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  synchronous active-high reset
i_valid  input  1  operand beat valid
o_ready  output  1  stage can accept a beat
i_a  input  N  multiplicand, signed QN.Q
i_b  input  N  multiplier, signed QN.Q
i_last  input  1  beat is the final beat of the vector
o_valid  output  1  result valid
i_ready  input  1  downstream accepts result
o_data  output  N  saturated dot product, signed QN.Q
o_ovr  output  1  sticky: any qmult ovr in this vector
o_sat  output  1  result or accumulator was clamped

Behaviour:
- Reset: the block is synchronous only and applies reset at the i_clk edge. Reset values: state=ACC, o_ready=1, o_valid=0, o_data=0, o_ovr=0, o_sat=0, accumulator=0, product register empty. Reset mid-vector discards the partial sum.
- Handshakes: an input beat is accepted when i_valid & o_ready at an edge. A result is consumed when o_valid & i_ready at an edge. No combinational path exists from i_ready to o_ready.
- Pipeline stage 1: at the acceptance edge, register the qmult result in p_reg, its ovr flag, i_last, and p_vld=1.
- Pipeline stage 2: at the next edge, if p_vld, acc <= acc + sign_ext(p_reg) and ovr_acc |= p_ovr. The add saturates at the (N+G)-bit limits; when that happens, set sat_acc.
- State ACC:
  - o_ready=1.
  - Accepting a beat with i_last moves the state to DRAIN. The same edge still loads p_reg.
- State DRAIN:
  - o_ready=0.
  - At the next edge the final product is added. In the same cycle the sum is saturated to N bits.
  - N-bit saturation: if sum bits [N+G-1:N-1] are not all equal, clamp to 0x7FFFFFFF (positive) or 0x80000000 (negative).
  - The result goes to o_data. o_ovr and o_sat get the final flags, where o_sat = sat_acc | N-bit clamp.
  - acc, sat_acc and ovr_acc clear to 0. o_valid is set to 1 and the state moves to DONE.
- State DONE:
  - o_ready=0. o_valid, o_data, o_ovr and o_sat hold stable while i_ready=0.
  - On result handshake, o_valid drops to 0 and o_ready returns to 1 on the following cycle (state ACC).
- Latency: when the last beat is accepted at edge k, o_valid is high after edge k+1. Peak throughput is one beat per cycle within a vector. Between vectors there is a bubble of 2 cycles plus any backpressure.
- Single-beat vector (i_last on the first beat) is legal: the result is that one product, saturated.
- i_valid=0 inside a vector: the accumulator holds and p_vld goes to 0. Gaps of any length are legal.
- Arithmetic: the product is the N-bit truncated qmult output, sign-extended by G bits. No rounding is applied.

Decomposition:
- Shared package q_fixed_pkg holds:
  - constants N, Q and G
  - the QMAX/QMIN saturation limits
  - the state enum {ACC, DRAIN, DONE}
  - a saturate-to-N function
- One sub-module: the existing qmult, instantiated once, combinational, ahead of p_reg.
- The FSM, the accumulator and the output register stay in qmac_accum.

Test Plan:
1. Basic vector: beats (1.5=0x00600000 × 2.0=0x00800000), then (1.0=0x00400000 × 1.0, last) -> o_data=0x01000000 (4.0), o_ovr=0, o_sat=0, o_valid one edge after the last accept.
2. Single-beat negative: (-1.0=0xFFC00000 × 0.5=0x00200000, last) -> o_data=0xFFE00000 (-0.5), flags 0.
3. Saturation: three beats of 400.0=0x64000000 × 1.0 -> o_data=0x7FFFFFFF, o_sat=1. The negated operands give o_data=0x80000000, o_sat=1.
4. Product overflow: (100.0=0x19000000 × 100.0, last) -> o_ovr=1. Then a clean next vector (1.0 × 1.0, last) -> o_data=0x00400000, o_ovr=0 (sticky cleared per vector).
5. Backpressure: hold i_ready=0 for 5 cycles after o_valid -> o_data and flags stable, o_ready=0, asserted i_valid not accepted. Release -> o_valid drops, o_ready=1 next cycle.
6. Reset mid-vector: accept 2 beats of 1.0 × 1.0, pulse i_rst, then send (1.0 × 1.0, last) -> o_data=0x00400000 and all outputs at reset values during reset.

Source files
------------

// File: rtl/q_fixed_pkg.sv
// Shared fixed-point constants, FSM encoding and N-bit saturation for the qmac datapath.
// Pure declarations: no logic, no latency, no flow control.
package q_fixed_pkg;

   localparam int N     = 32;
   localparam int Q     = 22;
   localparam int G     = 8;
   localparam int ACC_W = N + G;

   localparam logic [N-1:0]     QMAX    = {1'b0, {(N-1){1'b1}}};
   localparam logic [N-1:0]     QMIN    = {1'b1, {(N-1){1'b0}}};
   localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   typedef enum logic [1:0] {
      ACC   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } state_e;

   typedef struct packed {
      logic         clamp;
      logic [N-1:0] data;
   } sat_t;

   // The value fits in N bits only when every bit from the N-bit sign upward agrees.
   function automatic sat_t sat_to_n(input logic [ACC_W-1:0] v);
      sat_t r;
      r.clamp = !((&v[ACC_W-1:N-1]) || !(|v[ACC_W-1:N-1]));
      r.data  = r.clamp ? (v[ACC_W-1] ? QMIN : QMAX) : v[N-1:0];
      return r;
   endfunction

endpackage

// File: rtl/qmult.sv
// Combinational signed Q-format multiply: truncated N-bit product plus overflow flag.
// Zero latency; no handshake, the caller owns flow control.
module qmult #(
   parameter int N = 32,
   parameter int Q = 22
) (
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   output logic [N-1:0] o_result,
   output logic         o_ovr
);

   logic signed [2*N-1:0] a_x;
   logic signed [2*N-1:0] b_x;
   logic signed [2*N-1:0] prod;
   logic                  unused_frac;

   assign a_x  = {{N{i_a[N-1]}}, i_a};
   assign b_x  = {{N{i_b[N-1]}}, i_b};
   assign prod = a_x * b_x;

   // Product is Q(2Q); keep bits [N+Q-1:Q] and flag anything above that is not sign copy.
   assign o_result    = prod[N+Q-1:Q];
   assign o_ovr       = !((&prod[2*N-1:N+Q-1]) || !(|prod[2*N-1:N+Q-1]));
   assign unused_frac = ^prod[Q-1:0];

endmodule

// File: rtl/qmac_accum.sv
// Streaming Q-format dot product: qmult -> product reg -> saturating accumulator; result 1 edge after last accept.
// o_ready drops from last accept until the result is taken; result held stable while i_ready is low.
module qmac_accum
   import q_fixed_pkg::*;
(
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   input  logic         i_last,
   output logic         o_valid,
   input  logic         i_ready,
   output logic [N-1:0] o_data,
   output logic         o_ovr,
   output logic         o_sat
);

   logic [N-1:0]     prod;
   logic             prod_ovr;

   state_e           state_q, state_d;
   logic [N-1:0]     p_reg_q, p_reg_d;
   logic             p_ovr_q, p_ovr_d;
   logic             p_vld_q, p_vld_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             ovr_acc_q, ovr_acc_d;
   logic             sat_acc_q, sat_acc_d;
   logic             o_valid_q, o_valid_d;
   logic [N-1:0]     o_data_q, o_data_d;
   logic             o_ovr_q, o_ovr_d;
   logic             o_sat_q, o_sat_d;

   logic             accept;
   logic [ACC_W:0]   add_wide;
   logic [ACC_W-1:0] acc_next;
   logic             ovr_next;
   logic             sat_next;
   sat_t             fin;

   qmult #(
      .N (N),
      .Q (Q)
   ) u_qmult (
      .i_a      (i_a),
      .i_b      (i_b),
      .o_result (prod),
      .o_ovr    (prod_ovr)
   );

   assign o_ready = (state_q == ACC);
   assign accept  = i_valid && o_ready;

   always_comb begin
      add_wide = {acc_q[ACC_W-1], acc_q} + {{(G+1){p_reg_q[N-1]}}, p_reg_q};
      acc_next = acc_q;
      ovr_next = ovr_acc_q;
      sat_next = sat_acc_q;
      if (p_vld_q) begin
         ovr_next = ovr_acc_q | p_ovr_q;
         // One extra bit catches wrap-around of the guarded accumulator.
         if (add_wide[ACC_W] != add_wide[ACC_W-1]) begin
            acc_next = add_wide[ACC_W] ? ACC_MIN : ACC_MAX;
            sat_next = 1'b1;
         end else begin
            acc_next = add_wide[ACC_W-1:0];
         end
      end
      fin = sat_to_n(acc_next);
   end

   always_comb begin
      state_d   = state_q;
      p_vld_d   = accept;
      p_reg_d   = accept ? prod : p_reg_q;
      p_ovr_d   = accept ? prod_ovr : p_ovr_q;
      acc_d     = acc_next;
      ovr_acc_d = ovr_next;
      sat_acc_d = sat_next;
      o_valid_d = o_valid_q;
      o_data_d  = o_data_q;
      o_ovr_d   = o_ovr_q;
      o_sat_d   = o_sat_q;
      case (state_q)
         ACC: begin
            if (accept && i_last) state_d = DRAIN;
         end
         DRAIN: begin
            // The final product lands in acc_next this cycle; publish it and start the next vector clean.
            o_valid_d = 1'b1;
            o_data_d  = fin.data;
            o_ovr_d   = ovr_next;
            o_sat_d   = sat_next | fin.clamp;
            acc_d     = '0;
            ovr_acc_d = 1'b0;
            sat_acc_d = 1'b0;
            state_d   = DONE;
         end
         DONE: begin
            if (i_ready) begin
               o_valid_d = 1'b0;
               state_d   = ACC;
            end
         end
         default: state_d = ACC;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= ACC;
         p_reg_q   <= '0;
         p_ovr_q   <= 1'b0;
         p_vld_q   <= 1'b0;
         acc_q     <= '0;
         ovr_acc_q <= 1'b0;
         sat_acc_q <= 1'b0;
         o_valid_q <= 1'b0;
         o_data_q  <= '0;
         o_ovr_q   <= 1'b0;
         o_sat_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         p_reg_q   <= p_reg_d;
         p_ovr_q   <= p_ovr_d;
         p_vld_q   <= p_vld_d;
         acc_q     <= acc_d;
         ovr_acc_q <= ovr_acc_d;
         sat_acc_q <= sat_acc_d;
         o_valid_q <= o_valid_d;
         o_data_q  <= o_data_d;
         o_ovr_q   <= o_ovr_d;
         o_sat_q   <= o_sat_d;
      end
   end

   assign o_valid = o_valid_q;
   assign o_data  = o_data_q;
   assign o_ovr   = o_ovr_q;
   assign o_sat   = o_sat_q;

endmodule

// File: tb/tb_qmac_accum.sv
// Scoreboard bench for qmac_accum: directed vectors with fixed expectations plus random vectors
// checked against an arithmetic reference model.
module tb_qmac_accum;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_valid;
   logic        o_ready;
   logic [31:0] i_a;
   logic [31:0] i_b;
   logic        i_last;
   logic        o_valid;
   logic        i_ready = 1'b1;
   logic [31:0] o_data;
   logic        o_ovr;
   logic        o_sat;

   typedef struct {
      logic [31:0] data;
      logic        ovr;
      logic        sat;
   } res_t;

   res_t        exp_q[$];
   logic [31:0] va[$];
   logic [31:0] vb[$];
   int          n_cmp   = 0;
   int          n_bad   = 0;
   int          rdy_mode = 0;

   localparam longint ACCMAX = 64'sd549755813887;
   localparam longint ACCMIN = -64'sd549755813888;
   localparam longint NMAX   = 64'sd2147483647;
   localparam longint NMIN   = -64'sd2147483648;

   qmac_accum dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_a     (i_a),
      .i_b     (i_b),
      .i_last  (i_last),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_data  (o_data),
      .o_ovr   (o_ovr),
      .o_sat   (o_sat)
   );

   always #5 clk = ~clk;

   // Downstream ready: 0 = always ready, 1 = random, 2 = stalled.
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       i_ready = 1'b1;
         1:       i_ready = 1'($urandom_range(0, 1));
         default: i_ready = 1'b0;
      endcase
   end

   always @(negedge clk) begin
      res_t e;
      if (!rst && o_valid && i_ready) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL result_unexpected got data=%h ovr=%b sat=%b", o_data, o_ovr, o_sat);
         end else begin
            e = exp_q.pop_front();
            if (o_data !== e.data || o_ovr !== e.ovr || o_sat !== e.sat) begin
               n_bad++;
               $display("FAIL result got data=%h ovr=%b sat=%b want data=%h ovr=%b sat=%b",
                        o_data, o_ovr, o_sat, e.data, e.ovr, e.sat);
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   // Called at a negedge; returns at the negedge following the accepting posedge.
   task automatic beat(input logic [31:0] a, input logic [31:0] b, input logic last);
      int n = 0;
      i_a = a; i_b = b; i_last = last; i_valid = 1'b1;
      while (!o_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (!o_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL beat_accept_timeout got=o_ready_low want=o_ready_high");
         i_valid = 1'b0;
         return;
      end
      @(negedge clk);
      i_valid = 1'b0;
   endtask

   task automatic send_beats(input bit gaps);
      for (int i = 0; i < va.size(); i++) begin
         beat(va[i], vb[i], i == va.size() - 1);
         if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      end
   endtask

   task automatic push_exp(input logic [31:0] d, input logic ovr, input logic sat);
      res_t e;
      e.data = d; e.ovr = ovr; e.sat = sat;
      exp_q.push_back(e);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain_timeout got=%0d pending want=0", exp_q.size());
         exp_q.delete();
      end
      @(negedge clk);
   endtask

   // Reference: exact integer products, truncate to 32 bits, clamp the 40-bit sum, then clamp to 32 bits.
   function automatic res_t model_vec();
      longint acc = 0;
      longint p;
      longint sh;
      res_t   r;
      r.ovr = 1'b0;
      r.sat = 1'b0;
      foreach (va[i]) begin
         p  = longint'(signed'(va[i])) * longint'(signed'(vb[i]));
         sh = p >>> 22;
         if (sh > NMAX || sh < NMIN) r.ovr = 1'b1;
         sh = longint'(signed'(sh[31:0]));
         acc = acc + sh;
         if (acc > ACCMAX) begin acc = ACCMAX; r.sat = 1'b1; end
         else if (acc < ACCMIN) begin acc = ACCMIN; r.sat = 1'b1; end
      end
      if (acc > NMAX) begin r.data = 32'h7FFF_FFFF; r.sat = 1'b1; end
      else if (acc < NMIN) begin r.data = 32'h8000_0000; r.sat = 1'b1; end
      else r.data = acc[31:0];
      return r;
   endfunction

   function automatic logic [31:0] rand_op();
      int s;
      if ($urandom_range(0, 3) == 0) return $urandom;
      s = int'($urandom_range(0, 67108863)) - 33554432;
      return 32'(s);
   endfunction

   initial begin
      int n;
      rst = 1'b1; i_valid = 1'b0; i_a = '0; i_b = '0; i_last = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_o_valid", 32'(o_valid), 32'd0);
      check("reset_o_ready", 32'(o_ready), 32'd1);
      check("reset_o_data",  o_data,       32'd0);
      check("reset_o_ovr",   32'(o_ovr),   32'd0);
      check("reset_o_sat",   32'(o_sat),   32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Basic two-beat vector with latency probe.
      push_exp(32'h0100_0000, 1'b0, 1'b0);
      beat(32'h0060_0000, 32'h0080_0000, 1'b0);
      beat(32'h0040_0000, 32'h0040_0000, 1'b1);
      check("lat_valid_k",  32'(o_valid), 32'd0);
      check("lat_ready_k",  32'(o_ready), 32'd0);
      @(negedge clk);
      check("lat_valid_k1", 32'(o_valid), 32'd1);
      wait_drain();

      push_exp(32'hFFE0_0000, 1'b0, 1'b0);
      beat(32'hFFC0_0000, 32'h0020_0000, 1'b1);
      wait_drain();

      push_exp(32'h7FFF_FFFF, 1'b0, 1'b1);
      va = '{32'h6400_0000, 32'h6400_0000, 32'h6400_0000};
      vb = '{32'h0040_0000, 32'h0040_0000, 32'h0040_0000};
      send_beats(1'b0);
      push_exp(32'h8000_0000, 1'b0, 1'b1);
      va = '{32'h9C00_0000, 32'h9C00_0000, 32'h9C00_0000};
      send_beats(1'b1);
      wait_drain();

      // 10000.0 wraps in 32 bits to -240.0 and flags overflow; the next vector starts clean.
      push_exp(32'hC400_0000, 1'b1, 1'b0);
      beat(32'h1900_0000, 32'h1900_0000, 1'b1);
      push_exp(32'h0040_0000, 1'b0, 1'b0);
      beat(32'h0040_0000, 32'h0040_0000, 1'b1);
      wait_drain();

      // Accumulator clamps at the 40-bit max, so the negative half no longer cancels it.
      va.delete(); vb.delete();
      for (int i = 0; i < 300; i++) begin va.push_back(32'h7FFF_FFFF); vb.push_back(32'h0040_0000); end
      for (int i = 0; i < 300; i++) begin va.push_back(32'h8000_0001); vb.push_back(32'h0040_0000); end
      push_exp(32'h8000_0000, 1'b0, 1'b1);
      send_beats(1'b0);
      wait_drain();

      // Backpressure: result must hold and no beat may be taken.
      rdy_mode = 2;
      @(negedge clk);
      push_exp(32'h0040_0000, 1'b0, 1'b0);
      beat(32'h0040_0000, 32'h0040_0000, 1'b1);
      n = 0;
      while (!o_valid && n < 20) begin @(negedge clk); n++; end
      i_a = 32'h0040_0000; i_b = 32'h0040_0000; i_last = 1'b1; i_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         check("bp_o_valid", 32'(o_valid), 32'd1);
         check("bp_o_data",  o_data,       32'h0040_0000);
         check("bp_o_flags", {30'd0, o_ovr, o_sat}, 32'd0);
         check("bp_o_ready", 32'(o_ready), 32'd0);
         @(negedge clk);
      end
      i_valid = 1'b0;
      rdy_mode = 0;
      @(negedge clk);
      @(negedge clk);
      check("bp_release_valid", 32'(o_valid), 32'd0);
      check("bp_release_ready", 32'(o_ready), 32'd1);
      wait_drain();

      // Reset mid-vector discards the partial sum.
      beat(32'h0040_0000, 32'h0040_0000, 1'b0);
      beat(32'h0040_0000, 32'h0040_0000, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_o_valid", 32'(o_valid), 32'd0);
      check("midrst_o_ready", 32'(o_ready), 32'd1);
      check("midrst_o_data",  o_data,       32'd0);
      check("midrst_flags",   {30'd0, o_ovr, o_sat}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      push_exp(32'h0040_0000, 1'b0, 1'b0);
      beat(32'h0040_0000, 32'h0040_0000, 1'b1);
      wait_drain();

      // Random vectors with input gaps and random downstream stalls.
      rdy_mode = 1;
      for (int v = 0; v < 60; v++) begin
         va.delete(); vb.delete();
         n = $urandom_range(1, 8);
         for (int i = 0; i < n; i++) begin va.push_back(rand_op()); vb.push_back(rand_op()); end
         exp_q.push_back(model_vec());
         send_beats(1'b1);
      end
      rdy_mode = 0;
      wait_drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
